// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data SRAM between the core MEM stage and the debug/loader port.
// The debug port is bounded-latency: after MAX_WAIT consecutive denials it wins over the core.
module dmem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  c_req,
  input  logic                  c_we,
  input  logic [31:0]           c_addr,
  input  logic [DATA_WIDTH-1:0] c_wdata,
  output logic                  c_gnt,
  output logic                  c_rvalid,
  output logic [DATA_WIDTH-1:0] c_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [31:0]           d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  localparam int unsigned CNT_WIDTH = 4;
  localparam logic [CNT_WIDTH-1:0] WAIT_LIMIT = CNT_WIDTH'(MAX_WAIT);

  logic [CNT_WIDTH-1:0]  wait_cnt;
  logic                  rsp_valid;
  logic                  rsp_sel;
  logic [ADDR_WIDTH-1:0] c_word;
  logic [ADDR_WIDTH-1:0] d_word;

  // Byte offset and high address bits are dropped; aliasing is intended.
  assign c_word = c_addr[ADDR_WIDTH+1:2];
  assign d_word = d_addr[ADDR_WIDTH+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{c_addr[31:ADDR_WIDTH+2], c_addr[1:0],
                              d_addr[31:ADDR_WIDTH+2], d_addr[1:0]};

  // Grant selection and SRAM control; everything is held idle while in reset.
  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (rst) begin
      if (d_req && (wait_cnt == WAIT_LIMIT)) begin
        d_gnt = 1'b1;
      end else if (c_req) begin
        c_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end
    end

    csb0  = 1'b1;
    web0  = 1'b1;
    addr0 = '0;
    din0  = '0;
    if (c_gnt) begin
      csb0  = 1'b0;
      web0  = ~c_we;
      addr0 = c_word;
      din0  = c_wdata;
    end else if (d_gnt) begin
      csb0  = 1'b0;
      web0  = ~d_we;
      addr0 = d_word;
      din0  = d_wdata;
    end
  end

  // Read data is steered to whichever port issued the read last cycle.
  always_comb begin
    c_rvalid = rsp_valid && !rsp_sel;
    d_rvalid = rsp_valid && rsp_sel;
    c_rdata  = c_rvalid ? dout0 : '0;
    d_rdata  = d_rvalid ? dout0 : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt  <= '0;
      rsp_valid <= 1'b0;
      rsp_sel   <= 1'b0;
    end else begin
      if (d_req && !d_gnt) begin
        if (wait_cnt < WAIT_LIMIT) begin
          wait_cnt <= wait_cnt + CNT_WIDTH'(1);
        end
      end else begin
        wait_cnt <= '0;
      end

      rsp_valid <= (c_gnt && !c_we) || (d_gnt && !d_we);
      if ((c_gnt && !c_we) || (d_gnt && !d_we)) begin
        rsp_sel <= d_gnt;
      end
    end
  end

endmodule
